// File: rtl/wb_pkg.sv
// Shared Wishbone definitions for the initiator and the wb_slave_* responders.
package wb_pkg;

    typedef enum logic [1:0] {
        MST_IDLE,
        MST_REQ,
        MST_DRAIN
    } wb_mst_state_t;

    localparam int WB_ADR_W           = 32;
    localparam int WB_DAT_W           = 32;
    localparam int WB_DEFAULT_TIMEOUT = 16;

endpackage

// File: rtl/wb_master_timeout.sv
// Saturating cycle counter with an expiry flag; bounds both the request and drain phases.
module wb_timeout_cnt
    import wb_pkg::*;
#(
    parameter int LIMIT = WB_DEFAULT_TIMEOUT
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int CW = $clog2(LIMIT);
    localparam logic [CW-1:0] LastCnt = CW'(LIMIT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Holds at LIMIT-1 so the flag stays asserted instead of wrapping.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != LastCnt)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == LastCnt);

endmodule

// File: rtl/wb_master.sv
// Wishbone classic single-transfer initiator: one command in, one bus cycle, one response pulse.
module wb_master
    import wb_pkg::*;
#(
    parameter  int TIMEOUT_CYCLES = WB_DEFAULT_TIMEOUT,
    parameter  int ADR_W          = WB_ADR_W,
    parameter  int DAT_W          = WB_DAT_W,
    localparam int SEL_W          = DAT_W / 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic             cmd_we_i,
    input  logic [ADR_W-1:0] cmd_adr_i,
    input  logic [DAT_W-1:0] cmd_dat_i,
    input  logic [SEL_W-1:0] cmd_sel_i,
    output logic             rsp_valid_o,
    output logic [DAT_W-1:0] rsp_dat_o,
    output logic             rsp_err_o,
    output logic             rsp_timeout_o,
    output logic             cyc_o,
    output logic             stb_o,
    output logic             we_o,
    output logic [ADR_W-1:0] adr_o,
    output logic [DAT_W-1:0] dat_o,
    output logic [SEL_W-1:0] sel_o,
    input  logic [DAT_W-1:0] dat_i,
    input  logic             ack_i,
    input  logic             err_i
);

    wb_mst_state_t    state_q;
    logic             cmdReady_q;
    logic             cyc_q;
    logic             stb_q;
    logic             we_q;
    logic [ADR_W-1:0] adr_q;
    logic [DAT_W-1:0] dat_q;
    logic [SEL_W-1:0] sel_q;
    logic             rspValid_q;
    logic [DAT_W-1:0] rspDat_q;
    logic             rspErr_q;
    logic             rspTimeout_q;

    logic cmdAccept;
    logic reqDone;
    logic drainDone;
    logic cntExpired;

    assign cmdAccept = (state_q == MST_IDLE) && cmd_valid_i && cmdReady_q;
    assign reqDone   = (state_q == MST_REQ) && (err_i || ack_i || cntExpired);
    // Responders release ack one cycle after stb falls, so wait it out before the next command.
    assign drainDone = (state_q == MST_DRAIN) && ((!ack_i && !err_i) || cntExpired);

    wb_timeout_cnt #(
        .LIMIT(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clr_i    (cmdAccept || reqDone),
        .en_i     ((state_q == MST_REQ) || (state_q == MST_DRAIN)),
        .expired_o(cntExpired)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= MST_IDLE;
            cmdReady_q   <= 1'b1;
            cyc_q        <= 1'b0;
            stb_q        <= 1'b0;
            we_q         <= 1'b0;
            adr_q        <= '0;
            dat_q        <= '0;
            sel_q        <= '0;
            rspValid_q   <= 1'b0;
            rspDat_q     <= '0;
            rspErr_q     <= 1'b0;
            rspTimeout_q <= 1'b0;
        end else begin
            rspValid_q <= 1'b0;
            case (state_q)
                MST_IDLE: begin
                    if (cmdAccept) begin
                        we_q       <= cmd_we_i;
                        adr_q      <= cmd_adr_i;
                        dat_q      <= cmd_dat_i;
                        sel_q      <= cmd_sel_i;
                        cyc_q      <= 1'b1;
                        stb_q      <= 1'b1;
                        cmdReady_q <= 1'b0;
                        state_q    <= MST_REQ;
                    end
                end
                MST_REQ: begin
                    if (reqDone) begin
                        cyc_q      <= 1'b0;
                        stb_q      <= 1'b0;
                        we_q       <= 1'b0;
                        rspValid_q <= 1'b1;
                        state_q    <= MST_DRAIN;
                        // Error wins over a simultaneous ack; only an acked read returns data.
                        if (err_i) begin
                            rspErr_q     <= 1'b1;
                            rspTimeout_q <= 1'b0;
                            rspDat_q     <= '0;
                        end else if (ack_i) begin
                            rspErr_q     <= 1'b0;
                            rspTimeout_q <= 1'b0;
                            rspDat_q     <= we_q ? '0 : dat_i;
                        end else begin
                            rspErr_q     <= 1'b1;
                            rspTimeout_q <= 1'b1;
                            rspDat_q     <= '0;
                        end
                    end
                end
                MST_DRAIN: begin
                    if (drainDone) begin
                        cmdReady_q <= 1'b1;
                        state_q    <= MST_IDLE;
                    end
                end
                default: begin
                    cyc_q      <= 1'b0;
                    stb_q      <= 1'b0;
                    cmdReady_q <= 1'b1;
                    state_q    <= MST_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready_o   = cmdReady_q;
    assign cyc_o         = cyc_q;
    assign stb_o         = stb_q;
    assign we_o          = we_q;
    assign adr_o         = adr_q;
    assign dat_o         = dat_q;
    assign sel_o         = sel_q;
    assign rsp_valid_o   = rspValid_q;
    assign rsp_dat_o     = rspDat_q;
    assign rsp_err_o     = rspErr_q;
    assign rsp_timeout_o = rspTimeout_q;

endmodule

// File: tb/tb_wb_master.sv
// Self-checking bench for wb_master: responder model plus a response scoreboard.
module tb_wb_master;

    localparam int TIMEOUT = 16;
    localparam int BOUND   = 100;

    localparam int MODE_NORMAL = 0;
    localparam int MODE_NEVER  = 1;
    localparam int MODE_BOTH   = 2;

    typedef struct {
        logic [31:0] dat;
        logic        err;
        logic        to;
    } rsp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmdValid;
    logic        cmdReady;
    logic        cmdWe;
    logic [31:0] cmdAdr;
    logic [31:0] cmdDat;
    logic [3:0]  cmdSel;
    logic        rspValid;
    logic [31:0] rspDat;
    logic        rspErr;
    logic        rspTimeout;
    logic        cycOut;
    logic        stbOut;
    logic        weOut;
    logic [31:0] adrOut;
    logic [31:0] datOut;
    logic [3:0]  selOut;
    logic [31:0] datIn;
    logic        ackIn;
    logic        errIn;

    int   checks = 0;
    int   fails  = 0;
    int   rspCount = 0;
    int   slaveMode = MODE_NORMAL;
    rsp_t expQ[$];

    logic ackReg = 1'b0;
    int   stbCnt = 0;

    wb_master #(
        .TIMEOUT_CYCLES(TIMEOUT),
        .ADR_W(32),
        .DAT_W(32)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .cmd_valid_i  (cmdValid),
        .cmd_ready_o  (cmdReady),
        .cmd_we_i     (cmdWe),
        .cmd_adr_i    (cmdAdr),
        .cmd_dat_i    (cmdDat),
        .cmd_sel_i    (cmdSel),
        .rsp_valid_o  (rspValid),
        .rsp_dat_o    (rspDat),
        .rsp_err_o    (rspErr),
        .rsp_timeout_o(rspTimeout),
        .cyc_o        (cycOut),
        .stb_o        (stbOut),
        .we_o         (weOut),
        .adr_o        (adrOut),
        .dat_o        (datOut),
        .sel_o        (selOut),
        .dat_i        (datIn),
        .ack_i        (ackIn),
        .err_i        (errIn)
    );

    always #5 clk = ~clk;

    // Responder: acks two cycles after first seeing stb, releases ack one cycle after stb falls.
    always @(posedge clk) begin
        if (!stbOut) begin
            stbCnt <= 0;
            ackReg <= 1'b0;
        end else begin
            stbCnt <= stbCnt + 1;
            if (slaveMode == MODE_NORMAL && stbCnt == 1) ackReg <= 1'b1;
        end
    end

    assign ackIn = ackReg | (slaveMode == MODE_BOTH && stbOut);
    assign errIn = (slaveMode == MODE_BOTH) && stbOut;
    assign datIn = ackReg ? 32'hAAAA_0000 : 32'h5555_5555;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Every response pulse is matched against the oldest expectation.
    always @(negedge clk) begin
        if (rspValid) begin
            rspCount++;
            if (expQ.size() == 0) begin
                checkOutput("strayRsp", 64'(rspValid), 64'd0);
            end else begin
                rsp_t e;
                e = expQ.pop_front();
                checkOutput("rspDat", 64'(rspDat), 64'(e.dat));
                checkOutput("rspErr", 64'(rspErr), 64'(e.err));
                checkOutput("rspTimeout", 64'(rspTimeout), 64'(e.to));
            end
        end
    end

    task automatic waitReady();
        int n = 0;
        while (!cmdReady && n < BOUND) begin
            @(negedge clk);
            n++;
        end
        checkOutput("readyWait", 64'(cmdReady), 64'd1);
    endtask

    task automatic applyStimulus(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                                 input logic [3:0] sel, input int mode, input int expStb,
                                 input int expGap, input logic [31:0] expDat,
                                 input logic expErr, input logic expTo);
        int   startCnt;
        int   stbLen = 0;
        int   gap = 0;
        logic busBad = 1'b0;
        logic drainStb = 1'b0;
        slaveMode = mode;
        waitReady();
        cmdValid = 1'b1;
        cmdWe    = we;
        cmdAdr   = adr;
        cmdDat   = dat;
        cmdSel   = sel;
        expQ.push_back('{dat: expDat, err: expErr, to: expTo});
        startCnt = rspCount;
        @(negedge clk);
        cmdValid = 1'b0;
        cmdWe    = ~we;
        cmdAdr   = $urandom;
        cmdDat   = $urandom;
        cmdSel   = ~sel;
        while (stbOut && stbLen < BOUND) begin
            if (!cycOut || weOut !== we || adrOut !== adr || datOut !== dat || selOut !== sel)
                busBad = 1'b1;
            stbLen++;
            @(negedge clk);
        end
        checkOutput("stbLen", 64'(stbLen), 64'(expStb));
        checkOutput("busHold", 64'(busBad), 64'd0);
        checkOutput("rspPulse", 64'(rspValid), 64'd1);
        while (!cmdReady && gap < BOUND) begin
            @(negedge clk);
            gap++;
            if (stbOut || cycOut) drainStb = 1'b1;
        end
        checkOutput("readyGap", 64'(gap), 64'(expGap));
        checkOutput("drainStb", 64'(drainStb), 64'd0);
        checkOutput("onePulse", 64'(rspCount - startCnt), 64'd1);
        checkOutput("rspHold", 64'(rspDat), 64'(expDat));
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int   startCnt;
        int   rises;
        int   firstRise;
        int   riseGap;
        logic prevStb;
        logic prevAck;
        logic prevReady;
        logic inDrain;
        logic drainBad;
        logic ackAtReady;

        rst      = 1'b1;
        cmdValid = 1'b0;
        cmdWe    = 1'b0;
        cmdAdr   = '0;
        cmdDat   = '0;
        cmdSel   = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rstReady", 64'(cmdReady), 64'd1);
        checkOutput("rstCyc", 64'(cycOut), 64'd0);
        checkOutput("rstStb", 64'(stbOut), 64'd0);
        checkOutput("rstRspValid", 64'(rspValid), 64'd0);
        checkOutput("rstRspDat", 64'(rspDat), 64'd0);
        checkOutput("rstRspErr", 64'(rspErr), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] read with 2-cycle ack");
        applyStimulus(1'b0, 32'h0000_0010, 32'h0, 4'hF, MODE_NORMAL, 3, 2, 32'hAAAA_0000, 1'b0, 1'b0);

        $display("[TB] write with 2-cycle ack");
        applyStimulus(1'b1, 32'h0000_0004, 32'h1234_5678, 4'hF, MODE_NORMAL, 3, 2, 32'h0, 1'b0, 1'b0);

        $display("[TB] responder never acks");
        applyStimulus(1'b0, 32'h0000_0040, 32'h0, 4'h3, MODE_NEVER, TIMEOUT, 1, 32'h0, 1'b1, 1'b1);

        $display("[TB] ack and err together");
        applyStimulus(1'b0, 32'h0000_0080, 32'h0, 4'hF, MODE_BOTH, 1, 1, 32'h0, 1'b1, 1'b0);

        $display("[TB] reset in second request cycle");
        slaveMode = MODE_NORMAL;
        waitReady();
        startCnt = rspCount;
        cmdValid = 1'b1;
        cmdWe    = 1'b0;
        cmdAdr   = 32'h0000_0100;
        cmdSel   = 4'hF;
        @(negedge clk);
        cmdValid = 1'b0;
        checkOutput("midStbFirst", 64'(stbOut), 64'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("midRstCyc", 64'(cycOut), 64'd0);
        checkOutput("midRstStb", 64'(stbOut), 64'd0);
        checkOutput("midRstReady", 64'(cmdReady), 64'd1);
        repeat (4) @(negedge clk);
        checkOutput("midRstNoRsp", 64'(rspCount - startCnt), 64'd0);
        applyStimulus(1'b0, 32'h0000_0010, 32'h0, 4'hF, MODE_NORMAL, 3, 2, 32'hAAAA_0000, 1'b0, 1'b0);

        $display("[TB] back-to-back with valid held");
        waitReady();
        startCnt = rspCount;
        expQ.push_back('{dat: 32'hAAAA_0000, err: 1'b0, to: 1'b0});
        expQ.push_back('{dat: 32'hAAAA_0000, err: 1'b0, to: 1'b0});
        cmdValid   = 1'b1;
        cmdWe      = 1'b0;
        cmdAdr     = 32'h0000_0020;
        cmdSel     = 4'hF;
        rises      = 0;
        firstRise  = 0;
        riseGap    = 0;
        prevStb    = stbOut;
        prevAck    = ackIn;
        prevReady  = cmdReady;
        inDrain    = 1'b0;
        drainBad   = 1'b0;
        ackAtReady = 1'b0;
        for (int i = 1; i <= 24; i++) begin
            @(negedge clk);
            if (stbOut && !prevStb) begin
                rises++;
                if (rises == 1) firstRise = i;
                if (rises == 2) begin
                    riseGap  = i - firstRise;
                    cmdValid = 1'b0;
                end
            end
            if (rspValid) inDrain = 1'b1;
            if (cmdReady) inDrain = 1'b0;
            if (inDrain && (stbOut || cycOut)) drainBad = 1'b1;
            if (cmdReady && !prevReady && prevAck) ackAtReady = 1'b1;
            prevStb   = stbOut;
            prevAck   = ackIn;
            prevReady = cmdReady;
        end
        checkOutput("b2bRises", 64'(rises), 64'd2);
        checkOutput("b2bRiseGap", 64'(riseGap), 64'd6);
        checkOutput("b2bPulses", 64'(rspCount - startCnt), 64'd2);
        checkOutput("b2bDrainStb", 64'(drainBad), 64'd0);
        checkOutput("b2bAckLow", 64'(ackAtReady), 64'd0);
        checkOutput("queueEmpty", 64'(expQ.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
